// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings for the RISC control unit. It holds the
//                opcode constants, the ALU function codes, the opcode to ALU
//                function table, the control-step enum and the instruction
//                class enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction opcodes (ir[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // ALU function codes driven on OpCode
  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd3;
  localparam logic [4:0] ALU_SHR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_ROR = 5'd6;
  localparam logic [4:0] ALU_ROL = 5'd7;
  localparam logic [4:0] ALU_NEG = 5'd8;
  localparam logic [4:0] ALU_NOT = 5'd9;
  localparam logic [4:0] ALU_INC = 5'd12;

  // Control steps; T0..T7 are consecutive so a step advances by +1
  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  // Instruction classes sharing one execute sequence
  typedef enum logic [3:0] {
    IC_LD    = 4'd0,
    IC_LDI   = 4'd1,
    IC_ST    = 4'd2,
    IC_RALU  = 4'd3,
    IC_IALU  = 4'd4,
    IC_UNARY = 4'd5,
    IC_BR    = 4'd6,
    IC_JR    = 4'd7,
    IC_IN    = 4'd8,
    IC_OUT   = 4'd9,
    IC_NOP   = 4'd10,
    IC_HALT  = 4'd11
  } iclass_e;

  // Opcode to ALU function table; immediate forms share the register form's code
  function automatic logic [4:0] alu_fn(input logic [4:0] op);
    logic [4:0] fn;
    fn = ALU_ADD;
    case (op)
      OP_ADD, OP_ADDI: fn = ALU_ADD;
      OP_SUB:          fn = ALU_SUB;
      OP_AND, OP_ANDI: fn = ALU_AND;
      OP_OR,  OP_ORI:  fn = ALU_OR;
      OP_SHR:          fn = ALU_SHR;
      OP_SHL:          fn = ALU_SHL;
      OP_ROR:          fn = ALU_ROR;
      OP_ROL:          fn = ALU_ROL;
      OP_NEG:          fn = ALU_NEG;
      OP_NOT:          fn = ALU_NOT;
      default:         fn = ALU_ADD;
    endcase
    return fn;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational opcode classifier. It groups opcodes that run
//                the same execute sequence. Unknown opcodes behave as nop.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output iclass_e    iclass_o
);

  // Map each opcode to its execute-sequence class
  always_comb begin
    iclass_o = IC_NOP;
    case (opcode_i)
      OP_LD:                  iclass_o = IC_LD;
      OP_LDI:                 iclass_o = IC_LDI;
      OP_ST:                  iclass_o = IC_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL:
                              iclass_o = IC_RALU;
      OP_ADDI, OP_ANDI, OP_ORI:
                              iclass_o = IC_IALU;
      OP_NEG, OP_NOT:         iclass_o = IC_UNARY;
      OP_BR:                  iclass_o = IC_BR;
      OP_JR:                  iclass_o = IC_JR;
      OP_IN:                  iclass_o = IC_IN;
      OP_OUT:                 iclass_o = IC_OUT;
      OP_HALT:                iclass_o = IC_HALT;
      default:                iclass_o = IC_NOP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired control sequencer. It steps through T0..T7 once
//                per cycle and drives the datapath strobes as Moore outputs
//                of the step register and the IR opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        BAout,
  output logic        Rout,
  output logic        Cout,
  output logic        InPortout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Rin,
  output logic        CONin,
  output logic        OutportIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  OpCode
);

  state_e     state_q, state_d;
  logic       stop_q, stop_d;
  iclass_e    iclass;
  logic       last_step;
  logic [4:0] opcode;
  logic       ir_unused;

  // The register fields are decoded by the datapath's select logic, not here
  assign opcode    = ir[31:27];
  assign ir_unused = ^ir[26:0];

  instr_decode u_instr_decode (
    .opcode_i (opcode),
    .iclass_o (iclass)
  );

  // Step register and pending-stop flag; clr aborts everything and drops the flag
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_RESET;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
    end
  end

  // Flag the final step of the current instruction's sequence
  always_comb begin
    last_step = 1'b0;
    case (state_q)
      ST_T2:   last_step = (iclass == IC_NOP);
      ST_T3:   last_step = (iclass inside {IC_JR, IC_IN, IC_OUT});
      ST_T4:   last_step = (iclass == IC_UNARY);
      ST_T5:   last_step = (iclass inside {IC_LDI, IC_RALU, IC_IALU});
      ST_T6:   last_step = (iclass == IC_BR);
      ST_T7:   last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // Next step: advance, wrap to T0 after the last step, or halt when a stop is pending
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q | stop;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default: begin
        if ((state_q == ST_T2) && (iclass == IC_HALT)) begin
          state_d = ST_HALT;
        end else if (last_step) begin
          // A stop raised in the last step itself still counts as pending
          state_d = (stop_q || stop) ? ST_HALT : ST_T0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  // Moore output decode; every strobe defaults low
  always_comb begin
    {PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn} = '0;
    {Gra, Grb, Grc, Read, Write} = '0;
    OpCode = '0;
    run    = !(state_q inside {ST_RESET, ST_HALT});
    case (state_q)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = ALU_INC; end
      ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          IC_RALU, IC_IALU:     begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          IC_UNARY: begin Grb = 1'b1; Rout = 1'b1; OpCode = alu_fn(opcode); Zin = 1'b1; end
          IC_BR:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          IC_JR:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          IC_IN:    begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_OUT:   begin Gra = 1'b1; Rout = 1'b1; OutportIn = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST: begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
          IC_RALU:  begin Grc = 1'b1; Rout = 1'b1; OpCode = alu_fn(opcode); Zin = 1'b1; end
          IC_IALU:  begin Cout = 1'b1; OpCode = alu_fn(opcode); Zin = 1'b1; end
          IC_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_BR:    begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (iclass)
          IC_LD, IC_ST:              begin Zlowout = 1'b1; MARin = 1'b1; end
          IC_LDI, IC_RALU, IC_IALU:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_BR:                     begin Cout = 1'b1; OpCode = ALU_ADD; Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (iclass)
          IC_LD: begin Read = 1'b1; MDRin = 1'b1; end
          IC_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          // Branch target is committed only when the condition flip-flop is set
          IC_BR: begin Zlowout = con_ff; PCin = con_ff; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (iclass)
          IC_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_ST: begin Write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Directed self-checking bench for control_unit. Every output
//                is packed into one vector and compared step by step against
//                hand-written strobe patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, con_ff, stop;
  logic [31:0] ir;
  logic        run, PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
  logic        Gra, Grb, Grc, Read, Write;
  logic [4:0]  OpCode;
  logic [26:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [26:0] M_RUN    = 27'd1 << 26;
  localparam logic [26:0] M_PCOUT  = 27'd1 << 25;
  localparam logic [26:0] M_ZLOW   = 27'd1 << 24;
  localparam logic [26:0] M_MDROUT = 27'd1 << 23;
  localparam logic [26:0] M_BAOUT  = 27'd1 << 22;
  localparam logic [26:0] M_ROUT   = 27'd1 << 21;
  localparam logic [26:0] M_COUT   = 27'd1 << 20;
  localparam logic [26:0] M_INPORT = 27'd1 << 19;
  localparam logic [26:0] M_PCIN   = 27'd1 << 18;
  localparam logic [26:0] M_MARIN  = 27'd1 << 17;
  localparam logic [26:0] M_MDRIN  = 27'd1 << 16;
  localparam logic [26:0] M_IRIN   = 27'd1 << 15;
  localparam logic [26:0] M_YIN    = 27'd1 << 14;
  localparam logic [26:0] M_ZIN    = 27'd1 << 13;
  localparam logic [26:0] M_RIN    = 27'd1 << 12;
  localparam logic [26:0] M_CONIN  = 27'd1 << 11;
  localparam logic [26:0] M_OUTIN  = 27'd1 << 10;
  localparam logic [26:0] M_GRA    = 27'd1 << 9;
  localparam logic [26:0] M_GRB    = 27'd1 << 8;
  localparam logic [26:0] M_GRC    = 27'd1 << 7;
  localparam logic [26:0] M_READ   = 27'd1 << 6;
  localparam logic [26:0] M_WRITE  = 27'd1 << 5;

  // Fetch patterns; OpCode sits in the low five bits
  localparam logic [26:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_ZIN | 27'd12;
  localparam logic [26:0] F1 = M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [26:0] F2 = M_RUN | M_MDROUT | M_IRIN;

  // Shared ld/st address-computation steps
  localparam logic [26:0] A3 = M_RUN | M_GRB | M_BAOUT | M_YIN;
  localparam logic [26:0] A4 = M_RUN | M_COUT | M_ZIN | 27'd2;
  localparam logic [26:0] A5 = M_RUN | M_ZLOW | M_MARIN;

  assign obs = {run, PCout, Zlowout, MDRout, BAout, Rout, Cout, InPortout,
                PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn,
                Gra, Grb, Grc, Read, Write, OpCode};

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .BAout(BAout), .Rout(Rout), .Cout(Cout), .InPortout(InPortout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .OpCode(OpCode)
  );

  always #5 clk = ~clk;

  // Move to the sampling point of the next control step
  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
    cycle(); cycle();
    n_checks++;
    if (obs !== 27'd0) begin n_fail++; $display("FAIL reset: got %h expected %h", obs, 27'd0); end
    clr = 1'b0;
    n_checks++;
    if (obs !== 27'd0) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, 27'd0); end
    cycle();
    n_checks++;
    if (obs !== F0) begin n_fail++; $display("FAIL first_t0: got %h expected %h", obs, F0); end
  endtask

  task automatic test_ld();
    logic [26:0] exp [9];
    exp = '{F0, F1, F2, A3, A4, A5, M_RUN | M_READ | M_MDRIN,
            M_RUN | M_MDROUT | M_GRA | M_RIN, F0};
    ir = 32'h0080_0075;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL ld step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 8) cycle();
    end
  endtask

  task automatic test_ralu_add();
    logic [26:0] exp [7];
    exp = '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YIN,
            M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd2,
            M_RUN | M_ZLOW | M_GRA | M_RIN, F0};
    ir = 32'h1800_0000;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL add step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 6) cycle();
    end
  endtask

  task automatic test_ialu_addi();
    logic [26:0] exp [7];
    exp = '{F0, F1, F2, M_RUN | M_GRB | M_ROUT | M_YIN,
            M_RUN | M_COUT | M_ZIN | 27'd2,
            M_RUN | M_ZLOW | M_GRA | M_RIN, F0};
    ir = 32'h5800_0000;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL addi step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 6) cycle();
    end
  endtask

  task automatic test_unary_neg();
    logic [26:0] exp [6];
    exp = '{F0, F1, F2,
            M_RUN | M_GRB | M_ROUT | M_ZIN | 27'(cpu_pkg::ALU_NEG),
            M_RUN | M_ZLOW | M_GRA | M_RIN, F0};
    ir = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL neg step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 5) cycle();
    end
  endtask

  task automatic test_br(input logic con);
    logic [26:0] exp [8];
    exp = '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_CONIN,
            M_RUN | M_PCOUT | M_YIN, M_RUN | M_COUT | M_ZIN | 27'd2,
            con ? (M_RUN | M_ZLOW | M_PCIN) : M_RUN, F0};
    ir = 32'h9000_0000;
    con_ff = con;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL br con=%0b step %0d: got %h expected %h", con, i, obs, exp[i]); end
      if (i < 7) cycle();
    end
    con_ff = 1'b0;
  endtask

  task automatic test_out();
    logic [26:0] exp [5];
    exp = '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_OUTIN, F0};
    ir = 32'hB000_0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL out step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 4) cycle();
    end
  endtask

  task automatic test_nop_unknown();
    logic [26:0] exp [5];
    exp = '{F0, F1, F2, F0, F1};
    ir = 32'hF800_0000;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL nop step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 4) cycle();
    end
    cycle(); cycle();
    n_checks++;
    if (obs !== F0) begin n_fail++; $display("FAIL nop realign: got %h expected %h", obs, F0); end
  endtask

  task automatic test_back_to_back();
    logic [26:0] exp [9];
    exp = '{F0, F1, F2, M_RUN | M_GRA | M_ROUT | M_PCIN,
            F0, F1, F2, M_RUN | M_INPORT | M_GRA | M_RIN, F0};
    ir = 32'h9800_0000;
    for (int i = 0; i < 9; i++) begin
      if (i == 4) ir = 32'hA800_0000;
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL jr_in step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 8) cycle();
    end
  endtask

  task automatic test_stop();
    logic [26:0] exp [8];
    exp = '{F0, F1, F2, A3, A4, A5, M_RUN | M_READ | M_MDRIN,
            M_RUN | M_MDROUT | M_GRA | M_RIN};
    ir = 32'h0080_0075;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) stop = 1'b0;
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL stop step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i == 4) stop = 1'b1;
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (obs !== 27'd0) begin n_fail++; $display("FAIL halt cycle %0d: got %h expected %h", i, obs, 27'd0); end
      cycle();
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    n_checks++;
    if (obs !== 27'd0) begin n_fail++; $display("FAIL halt_clr: got %h expected %h", obs, 27'd0); end
    cycle();
    n_checks++;
    if (obs !== F0) begin n_fail++; $display("FAIL halt_restart: got %h expected %h", obs, F0); end
  endtask

  task automatic test_clr_abort();
    logic [26:0] exp [7];
    exp = '{F0, F1, F2, A3, A4, A5, M_RUN | M_GRA | M_ROUT | M_MDRIN};
    ir = 32'h1000_0000;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL st step %0d: got %h expected %h", i, obs, exp[i]); end
      if (i < 6) cycle();
    end
    clr = 1'b1;
    cycle();
    n_checks++;
    if (obs !== 27'd0) begin n_fail++; $display("FAIL abort_reset: got %h expected %h", obs, 27'd0); end
    clr = 1'b0;
    n_checks++;
    if (Write !== 1'b0) begin n_fail++; $display("FAIL abort_write: got %b expected 0", Write); end
    cycle();
    n_checks++;
    if (obs !== F0) begin n_fail++; $display("FAIL abort_restart: got %h expected %h", obs, F0); end
  endtask

  task automatic test_halt_instr();
    logic [26:0] exp [6];
    exp = '{F0, F1, F2, 27'd0, 27'd0, 27'd0};
    ir = 32'hD000_0000;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs !== exp[i]) begin n_fail++; $display("FAIL halt_op step %0d: got %h expected %h", i, obs, exp[i]); end
      cycle();
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
    n_checks++;
    if (obs !== F0) begin n_fail++; $display("FAIL halt_op_restart: got %h expected %h", obs, F0); end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_ralu_add();
    test_ialu_addi();
    test_unary_neg();
    test_br(1'b0);
    test_br(1'b1);
    test_out();
    test_nop_unknown();
    test_back_to_back();
    test_stop();
    test_clr_abort();
    test_halt_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
